// File: rtl/player_pkg.sv
// Shared types and screen constants for the player motion block.
package player_pkg;

  localparam int VEL_W    = 6;
  localparam int Y_W      = 9;
  localparam int CALC_W   = 10;
  localparam int SCREEN_H = 480;
  localparam int PLAYER_H = 60;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } state_e;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge pulse from a level input that is already synchronous to clk_i.
module edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  // Remember the previous level so a held input yields a single pulse.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) d_q <= 1'b0;
    else         d_q <= d_i;
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/player_motion.sv
// Per-frame jump/gravity physics for the player sprite's top-edge y.
// Optional build macro DOUBLE_JUMP_EN allows one extra jump per airtime.
//
// state  | meaning
// GROUND | resting at GroundY, waiting for a jump request
// RISE   | moving up, speed shrinking by Gravity each frame
// FALL   | moving down, speed growing to MaxFall until landing
module player_motion
  import player_pkg::*;
#(
  parameter int GroundY = SCREEN_H - PLAYER_H,
  parameter int CeilY   = 0,
  parameter int JumpVel = 12,
  parameter int Gravity = 1,
  parameter int MaxFall = 12
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           frame_tick_i,
  input  logic           jump_i,
  input  logic           game_run_i,
  output logic [Y_W-1:0] luc_loc_o,
  output logic           player_en_o,
  output logic           airborne_o
);

  logic [Y_W-1:0]    y_q, y_d;
  logic [VEL_W-1:0]  vel_q, vel_d;
  state_e            state_q, state_d;
  logic              pend_q;
  logic              air_q;
  logic              en_q;
  logic              jump_edge;
  logic              take;

  logic [CALC_W-1:0] y_w, vel_w, ceil_lim, vn_raw, vn, y_dn;
  logic [Y_W-1:0]    y_up;

`ifdef DOUBLE_JUMP_EN
  logic              air_avail_q;
  logic              air_jump;
`endif

  edge_detect u_jump_edge (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (jump_i),
    .rise_o (jump_edge)
  );

  // An edge landing on the tick cycle still counts for that tick.
  assign take = pend_q | jump_edge;

  assign y_w      = {{(CALC_W-Y_W){1'b0}}, y_q};
  assign vel_w    = {{(CALC_W-VEL_W){1'b0}}, vel_q};
  assign ceil_lim = CALC_W'(CeilY) + vel_w;
  // Only used when y_q >= CeilY+vel_q, so this cannot wrap.
  assign y_up     = y_q - Y_W'(vel_q);
  assign vn_raw   = vel_w + CALC_W'(Gravity);
  assign vn       = (vn_raw > CALC_W'(MaxFall)) ? CALC_W'(MaxFall) : vn_raw;
  assign y_dn     = y_w + vn;

  // Next position/velocity/state for the coming frame tick.
  always_comb begin
    y_d     = y_q;
    vel_d   = vel_q;
    state_d = state_q;
`ifdef DOUBLE_JUMP_EN
    air_jump = 1'b0;
`endif
    case (state_q)
      GROUND: begin
        if (take) begin
          state_d = RISE;
          vel_d   = VEL_W'(JumpVel);
        end
      end
      RISE: begin
        if (y_w < ceil_lim) begin
          y_d     = Y_W'(CeilY);
          vel_d   = '0;
          state_d = FALL;
        end else begin
          y_d = y_up;
          if (vel_w <= CALC_W'(Gravity)) begin
            vel_d   = '0;
            state_d = FALL;
          end else begin
            vel_d = vel_q - VEL_W'(Gravity);
          end
        end
      end
      FALL: begin
        if (y_dn >= CALC_W'(GroundY)) begin
          y_d     = Y_W'(GroundY);
          vel_d   = '0;
          state_d = GROUND;
        end else begin
          y_d   = y_dn[Y_W-1:0];
          vel_d = vn[VEL_W-1:0];
        end
      end
      default: begin
        y_d     = Y_W'(GroundY);
        vel_d   = '0;
        state_d = GROUND;
      end
    endcase
`ifdef DOUBLE_JUMP_EN
    if ((state_q != GROUND) && take && air_avail_q) begin
      y_d      = y_q;
      vel_d    = VEL_W'(JumpVel);
      state_d  = RISE;
      air_jump = 1'b1;
    end
`endif
  end

  // FSM and registered outputs; everything moves only on a running frame tick.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      y_q     <= Y_W'(GroundY);
      vel_q   <= '0;
      state_q <= GROUND;
      pend_q  <= 1'b0;
      air_q   <= 1'b0;
      en_q    <= 1'b1;
    end else begin
      en_q <= 1'b1;
      if (!game_run_i) begin
        pend_q <= 1'b0;
      end else if (frame_tick_i) begin
        pend_q  <= 1'b0;
        y_q     <= y_d;
        vel_q   <= vel_d;
        state_q <= state_d;
        air_q   <= (state_d != GROUND);
      end else if (jump_edge) begin
        pend_q <= 1'b1;
      end
    end
  end

`ifdef DOUBLE_JUMP_EN
  // One air jump per airtime, re-armed on landing.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      air_avail_q <= 1'b1;
    end else if (game_run_i && frame_tick_i) begin
      if (state_d == GROUND) air_avail_q <= 1'b1;
      else if (air_jump)     air_avail_q <= 1'b0;
    end
  end
`endif

  assign luc_loc_o   = y_q;
  assign player_en_o = en_q;
  assign airborne_o  = air_q;

endmodule

// File: tb/tb_player_motion.sv
// Scoreboard bench for player_motion: stimulus queues expected outputs,
// monitors pop and compare one clock after every tick or reset edge.
module tb_player_motion;

  typedef struct packed {
    logic [8:0] y;
    logic       air;
    logic       en;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       frame_tick_i;
  logic       jump_i;
  logic       game_run_i;
  logic [8:0] y0, y60;
  logic       air0, air60, en0, en60;

  exp_t  q0[$];
  exp_t  q60[$];
  int    n_chk  = 0;
  int    n_pass = 0;
  bit    chk60  = 1'b0;
  string phase  = "reset";

  always #5 clk = ~clk;

  player_motion u_dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .frame_tick_i (frame_tick_i),
    .jump_i       (jump_i),
    .game_run_i   (game_run_i),
    .luc_loc_o    (y0),
    .player_en_o  (en0),
    .airborne_o   (air0)
  );

  player_motion #(.JumpVel(60)) u_dut60 (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .frame_tick_i (frame_tick_i),
    .jump_i       (jump_i),
    .game_run_i   (game_run_i),
    .luc_loc_o    (y60),
    .player_en_o  (en60),
    .airborne_o   (air60)
  );

  function automatic exp_t ex(input int y, input bit air);
    exp_t e;
    e.y   = 9'(y);
    e.air = air;
    e.en  = 1'b1;
    return e;
  endfunction

  // Default jump (JumpVel=12, Gravity=1, MaxFall=12): k ticks after the start tick.
  function automatic int traj_y(input int k);
    if (k <= 0)  return 420;
    if (k <= 12) return 420 - (12 * k - (k * (k - 1)) / 2);
    if (k <= 23) return 342 + ((k - 12) * (k - 11)) / 2;
    return 420;
  endfunction

  function automatic bit traj_air(input int k);
    return (k >= 0) && (k <= 23);
  endfunction

  task automatic compare(input string nm, input bit have, input exp_t e,
                         input logic [8:0] y, input logic a, input logic en);
    n_chk++;
    if (!have)
      $display("FAIL %s: output update with empty scoreboard (got y=%0d air=%0b en=%0b)",
               nm, y, a, en);
    else if ({y, a, en} !== e)
      $display("FAIL %s: got y=%0d air=%0b en=%0b, want y=%0d air=%0b en=%0b",
               nm, y, a, en, e.y, e.air, e.en);
    else
      n_pass++;
  endtask

  // Main DUT monitor.
  initial begin : mon0
    exp_t e;
    bit   have;
    forever begin
      @(posedge clk);
      if (frame_tick_i || !rst_ni) begin
        @(negedge clk);
        have = (q0.size() > 0);
        e    = have ? q0.pop_front() : '0;
        compare({phase, "/main"}, have, e, y0, air0, en0);
      end
    end
  end

  // JumpVel=60 DUT monitor, active only in its own phase.
  initial begin : mon60
    exp_t e;
    bit   have;
    forever begin
      @(posedge clk);
      if (chk60 && (frame_tick_i || !rst_ni)) begin
        @(negedge clk);
        have = (q60.size() > 0);
        e    = have ? q60.pop_front() : '0;
        compare({phase, "/jv60"}, have, e, y60, air60, en60);
      end
    end
  end

  task automatic tick(input exp_t e0);
    @(negedge clk);
    frame_tick_i = 1'b1;
    q0.push_back(e0);
    @(negedge clk);
    frame_tick_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic tick2(input exp_t e0, input exp_t e60);
    @(negedge clk);
    frame_tick_i = 1'b1;
    q0.push_back(e0);
    q60.push_back(e60);
    @(negedge clk);
    frame_tick_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic press();
    @(negedge clk);
    jump_i = 1'b1;
    repeat (2) @(negedge clk);
    jump_i = 1'b0;
  endtask

`ifdef DOUBLE_JUMP_EN
  int dj_y[29] = '{378, 366, 355, 345, 336, 328, 321, 315, 310, 306, 303, 301, 300,
                   301, 303, 306, 310, 315, 321, 328, 336, 345, 355, 366, 378,
                   390, 402, 414, 420};
`endif
  int v60_y[10] = '{420, 360, 301, 243, 186, 130, 75, 21, 0, 1};

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst_ni       = 1'b0;
    frame_tick_i = 1'b0;
    jump_i       = 1'b0;
    game_run_i   = 1'b1;
    for (int i = 0; i < 3; i++) q0.push_back(ex(420, 0));
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;

    phase = "idle";
    for (int i = 0; i < 50; i++) tick(ex(420, 0));

    phase = "single_jump";
    press();
    for (int k = 0; k <= 24; k++) tick(ex(traj_y(k), traj_air(k)));

    phase = "same_cycle_edge";
    @(negedge clk);
    frame_tick_i = 1'b1;
    jump_i       = 1'b1;
    q0.push_back(ex(traj_y(0), 1));
    @(negedge clk);
    frame_tick_i = 1'b0;
    @(negedge clk);
    jump_i = 1'b0;
    for (int k = 1; k <= 4; k++) tick(ex(traj_y(k), 1));

    phase = "paused";
    @(negedge clk);
    game_run_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) press();
      tick(ex(378, 1));
    end
    @(negedge clk);
    game_run_i = 1'b1;
    phase = "resumed";
    for (int k = 5; k <= 24; k++) tick(ex(traj_y(k), traj_air(k)));

    phase = "pause_clears_pend";
    @(negedge clk);
    game_run_i = 1'b0;
    press();
    @(negedge clk);
    game_run_i = 1'b1;
    tick(ex(420, 0));

    phase = "edge_after_tick";
    @(negedge clk);
    frame_tick_i = 1'b1;
    q0.push_back(ex(420, 0));
    @(negedge clk);
    frame_tick_i = 1'b0;
    jump_i       = 1'b1;
    repeat (2) @(negedge clk);
    jump_i = 1'b0;
    for (int k = 0; k <= 24; k++) tick(ex(traj_y(k), traj_air(k)));

    phase = "air_press";
    press();
    for (int k = 0; k <= 4; k++) tick(ex(traj_y(k), 1));
    press();
`ifdef DOUBLE_JUMP_EN
    for (int i = 0; i < 29; i++) begin
      if (i == 19) press();
      tick(ex(dj_y[i], i != 28));
    end
`else
    for (int k = 5; k <= 24; k++) begin
      if (k == 15) press();
      tick(ex(traj_y(k), traj_air(k)));
    end
`endif
    tick(ex(420, 0));

    phase = "jumpvel60";
    @(negedge clk);
    chk60  = 1'b1;
    rst_ni = 1'b0;
    q0.push_back(ex(420, 0));
    q60.push_back(ex(420, 0));
    @(negedge clk);
    rst_ni = 1'b1;
    press();
    for (int k = 0; k <= 9; k++) tick2(ex(traj_y(k), 1), ex(v60_y[k], 1));
    @(negedge clk);
    rst_ni = 1'b0;
    q0.push_back(ex(420, 0));
    q60.push_back(ex(420, 0));
    @(negedge clk);
    rst_ni = 1'b1;
    tick2(ex(420, 0), ex(420, 0));

    repeat (3) @(negedge clk);
    n_chk++;
    if ((q0.size() != 0) || (q60.size() != 0))
      $display("FAIL drain: expected values left unconsumed main=%0d jv60=%0d, want 0/0",
               q0.size(), q60.size());
    else
      n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
